// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM state type and parameter helpers for the APB strobe memory slave
package apb_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} apb_state_t;
  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction
  function automatic bit params_ok(input int addr_w, input int data_w, input int depth, input int ws);
    return (data_w == 8 || data_w == 16 || data_w == 32 || data_w == 64) && depth >= 2 &&
           ws >= 0 && ws <= 15 && addr_w < 63 &&
           (longint'(depth) * longint'(data_w / 8) <= (longint'(1) << addr_w));
  endfunction
endpackage

// File: rtl/apb_strb_ram.sv
// apb_strb_ram: DEPTH x DATA_W storage with per-byte write enables and a combinational read port
module apb_strb_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [DATA_W/8-1:0]      i_strb,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_W-1:0]        o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  // byte-lane write; contents are deliberately not reset
  always_ff @(posedge i_clk) begin
    if (i_we)
      for (int b = 0; b < DATA_W / 8; b++)
        if (i_strb[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
  end
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/apb_strb_mem_slave.sv
// apb_strb_mem_slave: APB4 scratch-RAM slave with byte strobes, wait states and error response
module apb_strb_mem_slave
  import apb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                        PCLK,
  input  logic                        PRESET,
  input  logic                        PSEL,
  input  logic                        PENABLE,
  input  logic                        PWRITE,
  input  logic [ADDR_W-1:0]           PADDR,
  input  logic [DATA_W-1:0]           PWDATA,
  input  logic [strb_w(DATA_W)-1:0]   PSTRB,
  output logic [DATA_W-1:0]           PRDATA,
  output logic                        PREADY,
  output logic                        PSLVERR
);
  localparam int STRB_W = strb_w(DATA_W);
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  if (!params_ok(ADDR_W, DATA_W, DEPTH, WAIT_STATES)) begin : g_bad_params
    $error("apb_strb_mem_slave: illegal parameter combination");
  end

  apb_state_t          r_state, w_next;
  logic [3:0]          r_cnt;
  logic                r_write, r_valid, r_ready, r_slverr;
  logic [IDX_W-1:0]    r_idx;
  logic [DATA_W-1:0]   r_wdata, r_rdata;
  logic [STRB_W-1:0]   r_strb;
  logic [ADDR_W-1:0]   w_idx;
  logic                w_valid, w_setup, w_cmpl, w_rise, w_sel_valid, w_sel_write;
  logic [IDX_W-1:0]    w_rd_idx;
  logic [DATA_W-1:0]   w_rd_data;

  // decode: word index and alignment/range check on the live address
  assign w_idx       = PADDR >> LSB;
  assign w_valid     = ((PADDR & ADDR_W'(STRB_W - 1)) == '0) && (64'(w_idx) < 64'(DEPTH));
  assign w_setup     = r_state == IDLE && PSEL && !PENABLE;
  assign w_cmpl      = r_state == DONE && PSEL && PENABLE;
  assign w_rise      = w_next == DONE && r_state != DONE;
  // with zero wait states the response is built from the live request, otherwise from the latched one
  assign w_sel_valid = w_setup ? w_valid : r_valid;
  assign w_sel_write = w_setup ? PWRITE : r_write;
  assign w_rd_idx    = w_setup ? IDX_W'(w_idx) : r_idx;

  // next-state: setup starts a transfer, PSEL loss aborts, completion returns to IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_setup ? (WS == 4'd0 ? DONE : WAIT) : IDLE;
      WAIT:    w_next = !PSEL ? IDLE : (r_cnt == 4'd1 ? DONE : WAIT);
      DONE:    w_next = (!PSEL || PENABLE) ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // wait-state counter: loaded at setup, counts down while waiting, otherwise parked at zero
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)                                r_cnt <= '0;
    else if (w_setup)                          r_cnt <= WS;
    else if (r_state == WAIT && w_next == WAIT) r_cnt <= r_cnt - 4'd1;
    else                                       r_cnt <= '0;
  end

  // request capture; later changes on the bus during the access phase are ignored
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_write <= 1'b0;
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_strb  <= '0;
    end else if (w_setup) begin
      r_write <= PWRITE;
      r_valid <= w_valid;
      r_idx   <= IDX_W'(w_idx);
      r_wdata <= PWDATA;
      r_strb  <= PSTRB;
    end
  end

  // registered response: data and error exist only while PREADY is high
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_ready  <= 1'b0;
      r_slverr <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_ready  <= w_next == DONE;
      r_slverr <= w_next == DONE && !w_sel_valid;
      r_rdata  <= w_next != DONE ? '0 :
                  w_rise ? ((w_sel_valid && !w_sel_write) ? w_rd_data : '0) : r_rdata;
    end
  end

  apb_strb_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .i_clk   (PCLK),
    .i_we    (w_cmpl && r_write && r_valid),
    .i_strb  (r_strb),
    .i_waddr (r_idx),
    .i_wdata (r_wdata),
    .i_raddr (w_rd_idx),
    .o_rdata (w_rd_data)
  );

  assign PREADY  = r_ready;
  assign PSLVERR = r_slverr;
  assign PRDATA  = r_rdata;
endmodule

// File: tb/tb_apb_strb_mem_slave.sv
// tb_apb_strb_mem_slave: table-driven, directed and randomized checks of two slave instances (2 and 0 wait states)
module tb_apb_strb_mem_slave;
  logic             pclk = 1'b0;
  logic             prst;
  logic [1:0]       psel;
  logic             pen, pwrite;
  logic [31:0]      paddr, pwdata;
  logic [3:0]       pstrb;
  logic [1:0][31:0] prdata;
  logic [1:0]       pready, pslverr;
  int               n_vec = 0;
  int               n_miss = 0;
  logic [31:0]      mdl [2][256];

  always #5 pclk = ~pclk;

  apb_strb_mem_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .WAIT_STATES(2)) u_ws2 (
    .PCLK(pclk), .PRESET(prst), .PSEL(psel[0]), .PENABLE(pen), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

  apb_strb_mem_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .WAIT_STATES(0)) u_ws0 (
    .PCLK(pclk), .PRESET(prst), .PSEL(psel[1]), .PENABLE(pen), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
    return a % 4 == 0 && a / 4 < 256;
  endfunction

  task automatic model_upd(input int k, input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (wr && addr_ok(a))
      for (int b = 0; b < 4; b++)
        if (s[b]) mdl[k][a / 4][8*b +: 8] = d[8*b +: 8];
  endtask

  // one complete transfer; garbage on the request lines during the access phase
  task automatic xfer(input int k, input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output logic err, output int lat, output bit leak);
    psel = 2'b00;
    psel[k] = 1'b1;
    pen = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    lat = 0; leak = 1'b0; rd = '0; err = 1'b0;
    @(posedge pclk); #1;
    pen = 1'b1; pwrite = 1'($urandom_range(0, 1)); paddr = $urandom; pwdata = $urandom; pstrb = 4'($urandom);
    for (int c = 1; c <= 20; c++) begin
      @(negedge pclk);
      if (pready[k]) begin
        lat = c; rd = prdata[k]; err = pslverr[k];
        break;
      end
      if (prdata[k] != 0 || pslverr[k]) leak = 1'b1;
      @(posedge pclk); #1;
    end
    @(posedge pclk); #1;
    psel = 2'b00; pen = 1'b0;
  endtask

  // transfer checked against the reference memory model
  task automatic run(input int k, input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input string nm);
    logic [31:0] rd, exp_rd;
    logic        err;
    int          lat;
    bit          leak;
    exp_rd = (!wr && addr_ok(a)) ? mdl[k][a / 4] : 32'h0;
    xfer(k, wr, a, d, s, rd, err, lat, leak);
    chk({nm, "_lat"}, 64'(lat), k == 0 ? 64'd3 : 64'd1);
    chk({nm, "_err"}, 64'(err), 64'(!addr_ok(a)));
    chk({nm, "_leak"}, 64'(leak), 64'd0);
    if (!wr) chk({nm, "_rd"}, 64'(rd), 64'(exp_rd));
    model_upd(k, wr, a, d, s);
  endtask

  initial begin
    logic [31:0] rd, a;
    logic        err;
    int          lat, sel, k;
    bit          leak, bad;
    tbl[0]  = '{1, 32'h010, 32'hABCD1234, 4'hF, 32'h0,        0};
    tbl[1]  = '{0, 32'h010, 32'h0,        4'h0, 32'hABCD1234, 0};
    tbl[2]  = '{1, 32'h010, 32'h55667788, 4'h3, 32'h0,        0};
    tbl[3]  = '{0, 32'h010, 32'h0,        4'hF, 32'hABCD7788, 0};
    tbl[4]  = '{1, 32'h010, 32'hFFFFFFFF, 4'h0, 32'h0,        0};
    tbl[5]  = '{0, 32'h010, 32'h0,        4'h0, 32'hABCD7788, 0};
    tbl[6]  = '{1, 32'h400, 32'h99999999, 4'hF, 32'h0,        1};
    tbl[7]  = '{1, 32'h012, 32'h12345678, 4'hF, 32'h0,        1};
    tbl[8]  = '{0, 32'h400, 32'h0,        4'h0, 32'h0,        1};
    tbl[9]  = '{0, 32'h010, 32'h0,        4'h0, 32'hABCD7788, 0};
    tbl[10] = '{0, 32'h011, 32'h0,        4'h0, 32'h0,        1};
    tbl[11] = '{1, 32'h3FC, 32'h0BADCAFE, 4'hF, 32'h0,        0};
    tbl[12] = '{0, 32'h3FC, 32'h0,        4'h0, 32'h0BADCAFE, 0};

    prst = 1'b1; psel = 2'b00; pen = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
    repeat (2) @(posedge pclk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_ready%0d", i), 64'(pready[i]), 64'd0);
      chk($sformatf("reset_slverr%0d", i), 64'(pslverr[i]), 64'd0);
      chk($sformatf("reset_rdata%0d", i), 64'(prdata[i]), 64'd0);
    end
    @(negedge pclk);
    prst = 1'b0;
    @(posedge pclk); #1;

    for (int i = 0; i < 13; i++) begin
      xfer(0, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].s, rd, err, lat, leak);
      chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'd3);
      chk($sformatf("tbl%0d_err", i), 64'(err), 64'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_leak", i), 64'(leak), 64'd0);
      if (!tbl[i].wr) chk($sformatf("tbl%0d_rd", i), 64'(rd), 64'(tbl[i].exp_rd));
      model_upd(0, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].s);
    end

    run(1, 1, 32'h020, 32'h11111111, 4'hF, "b2b_wr");
    run(1, 0, 32'h020, 32'h0, 4'h0, "b2b_rd");
    run(0, 1, 32'h020, 32'h11111111, 4'hF, "pre_wr");

    psel = 2'b01; pen = 1'b0; pwrite = 1'b1; paddr = 32'h020; pwdata = 32'hDEADBEEF; pstrb = 4'hF;
    @(posedge pclk); #1;
    pen = 1'b1;
    @(negedge pclk);
    prst = 1'b1;
    #1;
    chk("rst_wait_ready", 64'(pready[0]), 64'd0);
    chk("rst_wait_rdata", 64'(prdata[0]), 64'd0);
    @(posedge pclk); #1;
    prst = 1'b0; psel = 2'b00; pen = 1'b0;
    @(posedge pclk); #1;
    run(0, 0, 32'h020, 32'h0, 4'h0, "after_rst_rd");

    psel = 2'b01; pen = 1'b0; pwrite = 1'b0; paddr = 32'h020;
    @(posedge pclk); #1;
    pen = 1'b1;
    repeat (3) @(negedge pclk);
    chk("rst_done_pre_ready", 64'(pready[0]), 64'd1);
    chk("rst_done_pre_rdata", 64'(prdata[0]), 64'h11111111);
    prst = 1'b1;
    #1;
    chk("rst_done_ready", 64'(pready[0]), 64'd0);
    chk("rst_done_rdata", 64'(prdata[0]), 64'd0);
    @(posedge pclk); #1;
    prst = 1'b0; psel = 2'b00; pen = 1'b0;
    @(posedge pclk); #1;

    psel = 2'b01; pen = 1'b0; pwrite = 1'b1; paddr = 32'h020; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
    @(posedge pclk); #1;
    pen = 1'b1;
    @(posedge pclk); #1;
    psel = 2'b00; pen = 1'b0;
    bad = 1'b0;
    repeat (4) begin
      @(negedge pclk);
      if (pready[0] || pslverr[0]) bad = 1'b1;
    end
    chk("abort_wait_ready", 64'(bad), 64'd0);
    @(posedge pclk); #1;
    run(0, 0, 32'h020, 32'h0, 4'h0, "abort_wait_rd");

    psel = 2'b01; pen = 1'b0; pwrite = 1'b1; paddr = 32'h020; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
    @(posedge pclk); #1;
    pen = 1'b1;
    repeat (3) @(negedge pclk);
    chk("abort_done_pre_ready", 64'(pready[0]), 64'd1);
    psel = 2'b00; pen = 1'b0;
    @(negedge pclk);
    chk("abort_done_ready", 64'(pready[0]), 64'd0);
    @(posedge pclk); #1;
    run(0, 0, 32'h020, 32'h0, 4'h0, "abort_done_rd");

    psel = 2'b11; pen = 1'b1; pwrite = 1'b1; paddr = 32'h020; pwdata = 32'h0; pstrb = 4'hF;
    bad = 1'b0;
    repeat (4) begin
      @(negedge pclk);
      if (pready != 2'b00) bad = 1'b1;
    end
    chk("penable_in_idle", 64'(bad), 64'd0);
    @(posedge pclk); #1;
    psel = 2'b00; pen = 1'b0;
    @(posedge pclk); #1;
    run(0, 0, 32'h020, 32'h0, 4'h0, "penable_idle_rd0");
    run(1, 0, 32'h020, 32'h0, 4'h0, "penable_idle_rd1");

    for (int kk = 0; kk < 2; kk++)
      for (int w = 0; w < 16; w++)
        run(kk, 1, 32'(w * 4), $urandom, 4'hF, "init");

    for (int i = 0; i < 160; i++) begin
      k = int'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      a = sel < 7 ? 32'($urandom_range(0, 15) * 4) :
          sel == 7 ? 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3)) :
          sel == 8 ? 32'h400 + 32'($urandom_range(0, 1000) * 4) : ($urandom | 32'h400);
      run(k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), $sformatf("rnd%0d", i));
      if ($urandom_range(0, 3) == 0) begin
        pen = 1'($urandom_range(0, 1));
        @(posedge pclk); #1;
        pen = 1'b0;
      end
    end

    for (int kk = 0; kk < 2; kk++)
      for (int w = 0; w < 16; w++)
        run(kk, 0, 32'(w * 4), 32'h0, 4'h0, "final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
